// File: rtl/ahb_gpio_input_conditioner.sv
// AHB-Lite slave that synchronises switches, debounces buttons and latches press flags/counts.
// Optional interrupt mask and IRQ output are built when GPIO_IN_IRQ_EN is defined.
`default_nettype none

module ahb_gpio_input_conditioner #(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [N_SW-1:0]   Switches,
  input  logic [N_BTN-1:0]  Buttons,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
`ifdef GPIO_IN_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_SWITCH  = 3'd0;
  localparam logic [2:0] A_BUTTON  = 3'd1;
  localparam logic [2:0] A_FLAGS   = 3'd2;
  localparam logic [2:0] A_COUNT   = 3'd3;
  localparam logic [2:0] A_IRQMASK = 3'd4;

  logic [N_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [N_BTN-1:0] btn_stable_q, btn_stable_d;
  logic [CW-1:0]    db_cnt_q [N_BTN];
  logic [CW-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] flags_q, flags_d;
  logic [7:0]       cnt_q [N_BTN];
  logic [7:0]       cnt_d [N_BTN];

  logic       valid_q, write_q;
  logic [2:0] addr_q;
  logic       accept;
  logic       wr_en, wr_flags, wr_count;

`ifdef GPIO_IN_IRQ_EN
  logic [N_BTN-1:0] mask_q, mask_d;
  logic             irq_q;
  logic             wr_mask;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:5], HADDR[1:0], HSIZE, HWDATA[31:N_BTN]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign wr_en    = valid_q & write_q;
  assign wr_flags = wr_en & (addr_q == A_FLAGS);
  assign wr_count = wr_en & (addr_q == A_COUNT);

  // A press event is the cycle in which an accepted level change goes 0->1.
  always_comb begin
    btn_stable_d = btn_stable_q;
    press_evt    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync_q[i] != btn_stable_q[i]) begin
        if (db_cnt_q[i] == CNT_MAX) begin
          btn_stable_d[i] = btn_sync_q[i];
          press_evt[i]    = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Press events win over a simultaneous software clear.
  always_comb begin
    flags_d = (flags_q & ~(wr_flags ? HWDATA[N_BTN-1:0] : {N_BTN{1'b0}})) | press_evt;
    for (int i = 0; i < N_BTN; i++) begin
      if (wr_count) begin
        cnt_d[i] = {7'd0, press_evt[i]};
      end else begin
        cnt_d[i] = cnt_q[i] + {7'd0, press_evt[i]};
      end
    end
  end

`ifdef GPIO_IN_IRQ_EN
  assign wr_mask = wr_en & (addr_q == A_IRQMASK);
  assign mask_d  = wr_mask ? HWDATA[N_BTN-1:0] : mask_q;
  assign IRQ     = irq_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      btn_stable_q <= '0;
      flags_q      <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
`ifdef GPIO_IN_IRQ_EN
      mask_q       <= '0;
      irq_q        <= 1'b0;
`endif
    end else begin
      sw_meta_q    <= Switches;
      sw_sync_q    <= sw_meta_q;
      btn_meta_q   <= Buttons;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      flags_q      <= flags_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      if (HREADY) begin
        valid_q <= accept;
        if (accept) begin
          addr_q  <= HADDR[4:2];
          write_q <= HWRITE;
        end
      end
`ifdef GPIO_IN_IRQ_EN
      mask_q       <= mask_d;
      irq_q        <= |(flags_q & mask_q);
`endif
    end
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        A_SWITCH: HRDATA[N_SW-1:0]  = sw_sync_q;
        A_BUTTON: HRDATA[N_BTN-1:0] = btn_stable_q;
        A_FLAGS:  HRDATA[N_BTN-1:0] = flags_q;
        A_COUNT: begin
          for (int i = 0; i < N_BTN; i++) begin
            HRDATA[8*i +: 8] = cnt_q[i];
          end
        end
`ifdef GPIO_IN_IRQ_EN
        A_IRQMASK: HRDATA[N_BTN-1:0] = mask_q;
`endif
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_gpio_input_conditioner.sv
// Directed bench for ahb_gpio_input_conditioner (20 ns clock, DEBOUNCE_CYCLES=16).
`default_nettype none

module tb_ahb_gpio_input_conditioner;

  localparam int N_SW  = 16;
  localparam int N_BTN = 2;
  localparam int DB    = 16;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [N_SW-1:0]   Switches;
  logic [N_BTN-1:0]  Buttons;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
`ifdef GPIO_IN_IRQ_EN
  logic              IRQ;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #10 HCLK = ~HCLK;

  ahb_gpio_input_conditioner #(.N_SW(N_SW), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .Switches(Switches), .Buttons(Buttons),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP)
`ifdef GPIO_IN_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    idle_bus();
    d = HRDATA;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic press_btn(input int i);
    Buttons[i] = 1'b1;
    wait_cycles(22);
    Buttons[i] = 1'b0;
    wait_cycles(22);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; Switches = 16'h0001; Buttons = '0; HREADY = 1'b1;
    HSIZE = 3'b010; HWDATA = '0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
    #5;
    n_total++;
    if (HRDATA !== 32'h0) $display("FAIL reset_hrdata_a got=%h exp=%h", HRDATA, 32'h0);
    else n_pass++;
    #6;
    HADDR = 32'hC;
    #1;
    n_total++;
    if (HRDATA !== 32'h0) $display("FAIL reset_hrdata_b got=%h exp=%h", HRDATA, 32'h0);
    else n_pass++;
    idle_bus();
    HRESETn = 1'b1;
    wait_cycles(3);
    begin
      logic [31:0] d;
      ahb_read(32'h0, d);
      n_total++;
      if (d !== 32'h1) $display("FAIL reset_switch got=%h exp=%h", d, 32'h1);
      else n_pass++;
      n_total++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
        $display("FAIL tie_offs got=%b%b exp=10", HREADYOUT, HRESP);
      else n_pass++;
    end
  endtask

  task automatic test_switch();
    Switches = 16'h0000;
    wait_cycles(3);
    Switches = 16'h0003;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
    @(posedge HCLK); #1;
    n_total++;
    if (HRDATA !== 32'h0) $display("FAIL switch_plus1 got=%h exp=%h", HRDATA, 32'h0);
    else n_pass++;
    @(posedge HCLK); #1;
    n_total++;
    if (HRDATA !== 32'h3) $display("FAIL switch_plus2 got=%h exp=%h", HRDATA, 32'h3);
    else n_pass++;
    idle_bus();
  endtask

  task automatic test_buttons();
    logic [31:0] d;
    Buttons[0] = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
    for (int k = 1; k <= 18; k++) begin
      @(posedge HCLK); #1;
      if (k == 17) begin
        n_total++;
        if (HRDATA !== 32'h0) $display("FAIL btn0_edge17 got=%h exp=%h", HRDATA, 32'h0);
        else n_pass++;
      end
      if (k == 18) begin
        n_total++;
        if (HRDATA !== 32'h1) $display("FAIL btn0_edge18 got=%h exp=%h", HRDATA, 32'h1);
        else n_pass++;
      end
    end
    idle_bus();
    wait_cycles(32);
    Buttons[0] = 1'b0;
    wait_cycles(22);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL btn0_flags got=%h exp=%h", d, 32'h1);
    else n_pass++;
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL btn0_count got=%h exp=%h", d, 32'h1);
    else n_pass++;
    press_btn(1);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL btn1_flags got=%h exp=%h", d, 32'h3);
    else n_pass++;
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0101) $display("FAIL btn1_count got=%h exp=%h", d, 32'h0101);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    Buttons[1] = 1'b1;
    wait_cycles(10);
    Buttons[1] = 1'b0;
    wait_cycles(22);
    Buttons[1] = 1'b1;
    wait_cycles(DB - 1);
    Buttons[1] = 1'b0;
    wait_cycles(22);
    ahb_read(32'h4, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL glitch_button got=%h exp=%h", d, 32'h0);
    else n_pass++;
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL glitch_flags got=%h exp=%h", d, 32'h3);
    else n_pass++;
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0101) $display("FAIL glitch_count got=%h exp=%h", d, 32'h0101);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    Buttons[0] = 1'b1;
    wait_cycles(5);
    HRESETn = 1'b0;
    #10;
    HRESETn = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
    for (int k = 1; k <= 18; k++) begin
      @(posedge HCLK); #1;
      if (k == 17) begin
        n_total++;
        if (HRDATA !== 32'h0) $display("FAIL rst_mid_edge17 got=%h exp=%h", HRDATA, 32'h0);
        else n_pass++;
      end
      if (k == 18) begin
        n_total++;
        if (HRDATA !== 32'h1) $display("FAIL rst_mid_edge18 got=%h exp=%h", HRDATA, 32'h1);
        else n_pass++;
      end
    end
    idle_bus();
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL rst_mid_count got=%h exp=%h", d, 32'h1);
    else n_pass++;
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL rst_mid_flags got=%h exp=%h", d, 32'h1);
    else n_pass++;
    Buttons[0] = 1'b0;
    wait_cycles(22);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    ahb_write(32'h8, 32'h3);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL w1c_all got=%h exp=%h", d, 32'h0);
    else n_pass++;
    Buttons[0] = 1'b1;
    wait_cycles(DB);
    ahb_write(32'h8, 32'h1);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL w1c_vs_press got=%h exp=%h", d, 32'h1);
    else n_pass++;
    Buttons[0] = 1'b0;
    wait_cycles(22);
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0002) $display("FAIL count_before_clr got=%h exp=%h", d, 32'h0002);
    else n_pass++;
    Buttons[1] = 1'b1;
    wait_cycles(DB);
    ahb_write(32'hC, 32'h0);
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0100) $display("FAIL count_clr_vs_press got=%h exp=%h", d, 32'h0100);
    else n_pass++;
    Buttons[1] = 1'b0;
    wait_cycles(22);
    ahb_write(32'h8, 32'h0);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL w1c_zero got=%h exp=%h", d, 32'h3);
    else n_pass++;
    ahb_write(32'h8, 32'h1);
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h2) $display("FAIL w1c_bit0 got=%h exp=%h", d, 32'h2);
    else n_pass++;
    ahb_write(32'hC, 32'hFFFF_FFFF);
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL count_clear got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_misc_regs();
    logic [31:0] d;
    ahb_write(32'h0, 32'hFFFF_FFFF);
    ahb_read(32'h0, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL switch_ro got=%h exp=%h", d, 32'h3);
    else n_pass++;
    ahb_write(32'h14, 32'hFFFF_FFFF);
    ahb_read(32'h14, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL raz_0x14 got=%h exp=%h", d, 32'h0);
    else n_pass++;
    ahb_write(32'h10, 32'h3);
    ahb_read(32'h10, d);
    n_total++;
`ifdef GPIO_IN_IRQ_EN
    if (d !== 32'h3) $display("FAIL irqmask_rw got=%h exp=%h", d, 32'h3);
    else n_pass++;
`else
    if (d !== 32'h0) $display("FAIL irqmask_raz got=%h exp=%h", d, 32'h0);
    else n_pass++;
`endif
  endtask

`ifdef GPIO_IN_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    ahb_write(32'h10, 32'h2);
    ahb_write(32'h8, 32'h3);
    wait_cycles(2);
    press_btn(0);
    n_total++;
    if (IRQ !== 1'b0) $display("FAIL irq_masked got=%b exp=0", IRQ);
    else n_pass++;
    Buttons[1] = 1'b1;
    wait_cycles(DB + 2);
    n_total++;
    if (IRQ !== 1'b0) $display("FAIL irq_at_flag got=%b exp=0", IRQ);
    else n_pass++;
    wait_cycles(1);
    n_total++;
    if (IRQ !== 1'b1) $display("FAIL irq_after_flag got=%b exp=1", IRQ);
    else n_pass++;
    Buttons[1] = 1'b0;
    wait_cycles(22);
    ahb_write(32'h8, 32'h2);
    n_total++;
    if (IRQ !== 1'b1) $display("FAIL irq_at_clear got=%b exp=1", IRQ);
    else n_pass++;
    wait_cycles(1);
    n_total++;
    if (IRQ !== 1'b0) $display("FAIL irq_after_clear got=%b exp=0", IRQ);
    else n_pass++;
    ahb_read(32'h8, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL irq_flags got=%h exp=%h", d, 32'h1);
    else n_pass++;
    ahb_write(32'hC, 32'h0);
  endtask
`endif

  task automatic test_wrap();
    logic [31:0] d;
    for (int n = 0; n < 255; n++) press_btn(0);
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h00FF) $display("FAIL count_255 got=%h exp=%h", d, 32'h00FF);
    else n_pass++;
    press_btn(0);
    ahb_read(32'hC, d);
    n_total++;
    if (d !== 32'h0000) $display("FAIL count_wrap got=%h exp=%h", d, 32'h0000);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_buttons();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_misc_regs();
`ifdef GPIO_IN_IRQ_EN
    test_irq();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
